fmap_read_seq: RTL and testbench

FMAP_READ_SEQ -- requirements
Module: fmap_read_seq

---
 rtl/cnn_pkg.sv | 18 +
 rtl/lat_pipe.sv | 33 +++
 rtl/fmap_read_seq.sv | 141 ++++++++++++++
 tb/tb_fmap_read_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the feature-map read sequencer.
//   seq_state_t : sequencer FSM state encoding
//   clog2_min1  : bit width needed to index 'value' entries, never below 1
package cnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // A 1-entry range still needs a 1-bit port, so clamp at 1.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/lat_pipe.sv
// Fixed-latency delay line for the read strobe and the final-read flag.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset, clears every stage
//   sample  : [0] read strobe, [1] final-read flag, captured every cycle
//   delayed : sample as it was DEPTH cycles earlier
module lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sample,
  output logic [1:0] delayed
);

  logic [1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= 2'b00;
      end
    end else begin
      stage[0] <= sample;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/fmap_read_seq.sv
// Feature-map read sequencer: sweeps addr (row-major within a channel),
// then chan, then pass, issuing one read per non-stalled RUN cycle, and
// waits for the memory latency to drain before pulsing done.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   start      : begins a sweep when sampled in IDLE
//   stall      : downstream not ready, holds the sweep
//   addr       : linear in-channel address row*COLS+col
//   chan, pass : current channel and pass indices
//   rd_en      : read strobe for addr/chan this cycle
//   data_valid : rd_en delayed by MEM_LAT cycles
//   data_last  : data_valid beat of the final read
//   busy       : high in RUN and DRAIN
//   done       : one-cycle completion pulse
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, counters at 0
// S_RUN   | issuing reads, one per cycle unless stalled
// S_DRAIN | final read issued, waiting MEM_LAT cycles
// S_DONE  | single cycle with done high
module fmap_read_seq
  import cnn_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int CHANNELS = 12,
  parameter int PASSES   = 1,
  parameter int MEM_LAT  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 stall,
  output logic [clog2_min1(ROWS*COLS)-1:0]     addr,
  output logic [clog2_min1(CHANNELS)-1:0]      chan,
  output logic [clog2_min1(PASSES)-1:0]        pass,
  output logic                                 rd_en,
  output logic                                 data_valid,
  output logic                                 data_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int AW = clog2_min1(ROWS*COLS);
  localparam int CW = clog2_min1(CHANNELS);
  localparam int PW = clog2_min1(PASSES);

  localparam logic [AW-1:0] ADDR_LAST  = AW'(ROWS*COLS - 1);
  localparam logic [CW-1:0] CHAN_LAST  = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] PASS_LAST  = PW'(PASSES - 1);
  // Drain down-counter reaches 0 on the last of MEM_LAT cycles.
  localparam logic [1:0]    DRAIN_LOAD = 2'(MEM_LAT - 1);

  seq_state_t state;
  logic [1:0] drain_cnt;
  logic       addr_term;
  logic       chan_term;
  logic       pass_term;
  logic       final_rd;
  logic [1:0] pipe_out;

  assign rd_en     = (state == S_RUN) && !stall;
  assign addr_term = (addr == ADDR_LAST);
  assign chan_term = (chan == CHAN_LAST);
  assign pass_term = (pass == PASS_LAST);
  assign final_rd  = rd_en && addr_term && chan_term && pass_term;
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      chan      <= '0;
      pass      <= '0;
      drain_cnt <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            addr  <= '0;
            chan  <= '0;
            pass  <= '0;
          end
        end
        S_RUN: begin
          if (rd_en) begin
            // Nested wrap: each counter only moves when the one below wraps.
            if (addr_term) begin
              addr <= '0;
              if (chan_term) begin
                chan <= '0;
                if (pass_term) begin
                  pass <= '0;
                end else begin
                  pass <= pass + PW'(1);
                end
              end else begin
                chan <= chan + CW'(1);
              end
            end else begin
              addr <= addr + AW'(1);
            end
            if (final_rd) begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  lat_pipe #(
    .DEPTH (MEM_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .sample  ({final_rd, rd_en}),
    .delayed (pipe_out)
  );

  assign data_valid = pipe_out[0];
  assign data_last  = pipe_out[1];

endmodule

// File: tb/tb_fmap_read_seq.sv
// Bench for fmap_read_seq: one default instance (a) and one small
// instance (b: 2x3, 2 channels, 2 passes, latency 3). Expected reads are
// queued when start is driven and popped as rd_en appears; data_valid,
// data_last and done are predicted from the popped reads' history.
module tb_fmap_read_seq;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a = 1'b1, start_a = 1'b0, stall_a = 1'b0;
  logic [3:0] addr_a;
  logic [3:0] chan_a;
  logic [0:0] pass_a;
  logic       rd_en_a, dv_a, dl_a, busy_a, done_a;

  logic       reset_b = 1'b1, start_b = 1'b0, stall_b = 1'b0;
  logic [2:0] addr_b;
  logic [0:0] chan_b;
  logic [0:0] pass_b;
  logic       rd_en_b, dv_b, dl_b, busy_b, done_b;

  fmap_read_seq u_dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .stall(stall_a),
    .addr(addr_a), .chan(chan_a), .pass(pass_a), .rd_en(rd_en_a),
    .data_valid(dv_a), .data_last(dl_a), .busy(busy_a), .done(done_a)
  );

  fmap_read_seq #(
    .ROWS(2), .COLS(3), .CHANNELS(2), .PASSES(2), .MEM_LAT(LAT_B)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .stall(stall_b),
    .addr(addr_b), .chan(chan_b), .pass(pass_b), .rd_en(rd_en_b),
    .data_valid(dv_b), .data_last(dl_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int p;
    int c;
    int a;
    bit last;
  } rd_t;

  rd_t q_a[$];
  rd_t q_b[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt_a = 0, rd_cnt_b = 0, dv_cnt_b = 0;
  int first_a = -1, last_a = 0, last_b = 0;
  logic [7:0] hr_a = '0, hl_a = '0, hr_b = '0, hl_b = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int which, input int rows, input int cols,
                      input int chs, input int passes);
    rd_t e;
    for (int p = 0; p < passes; p++)
      for (int c = 0; c < chs; c++)
        for (int a = 0; a < rows*cols; a++) begin
          e.p = p;
          e.c = c;
          e.a = a;
          e.last = (p == passes-1) && (c == chs-1) && (a == rows*cols-1);
          if (which == 0) q_a.push_back(e);
          else q_b.push_back(e);
        end
  endtask

  // Monitor a
  always @(negedge clk) begin
    rd_t e;
    logic nl;
    nl = 1'b0;
    chk("a_dv", dv_a, reset_a ? 1'b0 : hr_a[LAT_A-1]);
    chk("a_dl", dl_a, reset_a ? 1'b0 : hl_a[LAT_A-1]);
    chk("a_done", done_a, reset_a ? 1'b0 : hl_a[LAT_A]);
    if (rd_en_a) begin
      rd_cnt_a++;
      if (first_a < 0) first_a = cyc;
      last_a = cyc;
      if (q_a.size() == 0) chk("a_rd_extra", rd_en_a, 0);
      else begin
        e = q_a.pop_front();
        chk("a_addr", addr_a, e.a);
        chk("a_chan", chan_a, e.c);
        chk("a_pass", pass_a, e.p);
        nl = e.last;
      end
    end
    if (reset_a) begin
      hr_a = '0;
      hl_a = '0;
    end else begin
      hr_a = {hr_a[6:0], rd_en_a};
      hl_a = {hl_a[6:0], nl};
    end
  end

  // Monitor b
  always @(negedge clk) begin
    rd_t e;
    logic nl;
    nl = 1'b0;
    chk("b_dv", dv_b, reset_b ? 1'b0 : hr_b[LAT_B-1]);
    chk("b_dl", dl_b, reset_b ? 1'b0 : hl_b[LAT_B-1]);
    chk("b_done", done_b, reset_b ? 1'b0 : hl_b[LAT_B]);
    if (dv_b) dv_cnt_b++;
    if (dl_b) chk("b_dl_at_24th", dv_cnt_b, 24);
    if (rd_en_b) begin
      rd_cnt_b++;
      last_b = cyc;
      if (q_b.size() == 0) chk("b_rd_extra", rd_en_b, 0);
      else begin
        e = q_b.pop_front();
        chk("b_addr", addr_b, e.a);
        chk("b_chan", chan_b, e.c);
        chk("b_pass", pass_b, e.p);
        nl = e.last;
      end
    end
    if (reset_b) begin
      hr_b = '0;
      hl_b = '0;
    end else begin
      hr_b = {hr_b[6:0], rd_en_b};
      hl_b = {hl_b[6:0], nl};
    end
  end

  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output int dc);
    int n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < limit) begin
      @(negedge clk);
      n++;
      d = (which == 0) ? done_a : done_b;
    end
    if (!d) chk(which == 0 ? "a_done_timeout" : "b_done_timeout", d, 1);
    dc = cyc;
  endtask

  task automatic wait_q_empty(input int which, input int limit);
    int n;
    n = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("q_empty_wait", (which == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin
    int dc, f, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_rd", rd_en_a, 0);
    chk("rst_a_addr", addr_a, 0);
    chk("rst_a_chan", chan_a, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_done", done_a, 0);
    chk("rst_b_rd", rd_en_b, 0);
    chk("rst_b_dv", dv_b, 0);
    chk("rst_b_busy", busy_b, 0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Plain sweep on a
    push(0, 4, 4, 12, 1);
    rd_cnt_a = 0; first_a = -1;
    pulse_start(0);
    chk("a_t1_busy", busy_a, 1);
    wait_done(0, 1000, dc);
    chk("a_t1_rdcnt", rd_cnt_a, 192);
    chk("a_t1_consec", last_a - first_a, 191);
    chk("a_t1_done_lat", dc - last_a, 2);
    chk("a_t1_q", q_a.size(), 0);

    // Stall at addr 7 chan 2
    @(posedge clk); #1;
    push(0, 4, 4, 12, 1);
    rd_cnt_a = 0; first_a = -1;
    pulse_start(0);
    n = 0;
    while (!(addr_a == 4'd7 && chan_a == 4'd2) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_t2_reach", addr_a, 7);
    stall_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("a_stall_rd", rd_en_a, 0);
      chk("a_stall_addr", addr_a, 7);
      chk("a_stall_chan", chan_a, 2);
      @(posedge clk); #1;
    end
    stall_a = 1'b0;
    wait_done(0, 1000, dc);
    chk("a_t2_rdcnt", rd_cnt_a, 192);
    chk("a_t2_span", last_a - first_a, 194);

    // Reset mid-RUN at chan 5
    @(posedge clk); #1;
    push(0, 4, 4, 12, 1);
    pulse_start(0);
    n = 0;
    while (chan_a != 4'd5 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_t4_reach", chan_a, 5);
    reset_a = 1'b1;
    q_a.delete();
    #1;
    chk("a_arst_rd", rd_en_a, 0);
    chk("a_arst_addr", addr_a, 0);
    chk("a_arst_chan", chan_a, 0);
    chk("a_arst_pass", pass_a, 0);
    chk("a_arst_dv", dv_a, 0);
    chk("a_arst_dl", dl_a, 0);
    chk("a_arst_busy", busy_a, 0);
    chk("a_arst_done", done_a, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0;
    rd_cnt_a = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("a_post_rst_rd", rd_cnt_a, 0);
    push(0, 4, 4, 12, 1);
    pulse_start(0);
    wait_done(0, 1000, dc);
    chk("a_t4_rdcnt", rd_cnt_a, 192);

    // start held high: two sweeps, one IDLE cycle between
    @(posedge clk); #1;
    push(0, 4, 4, 12, 1);
    push(0, 4, 4, 12, 1);
    rd_cnt_a = 0;
    start_a = 1'b1;
    wait_done(0, 1000, dc);
    n = 0;
    f = -1;
    while (f < 0 && n < 10) begin
      @(negedge clk);
      n++;
      if (rd_en_a) f = cyc;
    end
    chk("a_t5_gap", f - dc, 2);
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(0, 1000, dc);
    chk("a_t5_rdcnt", rd_cnt_a, 384);
    repeat (5) @(posedge clk);
    #1;
    chk("a_t5_q", q_a.size(), 0);
    chk("a_t5_idle", busy_a, 0);

    // Small config on b, stall held through DRAIN
    push(1, 2, 3, 2, 2);
    rd_cnt_b = 0; dv_cnt_b = 0;
    pulse_start(1);
    wait_q_empty(1, 100);
    chk("b_drain_busy", busy_b, 1);
    chk("b_drain_rd", rd_en_b, 0);
    stall_b = 1'b1;
    wait_done(1, 100, dc);
    stall_b = 1'b0;
    chk("b_done_lat", dc - last_b, 4);
    chk("b_rdcnt", rd_cnt_b, 24);
    chk("b_dvcnt", dv_cnt_b, 24);

    // Reset b mid-DRAIN
    @(posedge clk); #1;
    push(1, 2, 3, 2, 2);
    pulse_start(1);
    wait_q_empty(1, 100);
    reset_b = 1'b1;
    q_b.delete();
    #1;
    chk("b_arst_busy", busy_b, 0);
    chk("b_arst_dv", dv_b, 0);
    chk("b_arst_done", done_b, 0);
    @(posedge clk); #1;
    reset_b = 1'b0;
    dv_cnt_b = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("b_post_rst_dv", dv_cnt_b, 0);
    chk("b_post_rst_done", done_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
